// File: rtl/multi_period_sequencer_pkg.sv
// Shared definitions for the multi-period control sequencer.
// Holds state codes, instruction classes, opcode/funct encodings, ALU op
// codes, fault causes, the packed control-strobe bundle and a small helper
// that picks the state following an instruction boundary.
package multi_period_sequencer_pkg;

  localparam int STATE_LEN = 3;

  typedef enum logic [STATE_LEN-1:0] {
    STATE_IF    = 3'd0,
    STATE_ID    = 3'd1,
    STATE_EX    = 3'd2,
    STATE_MEM   = 3'd3,
    STATE_WB    = 3'd4,
    STATE_HALT  = 3'd5,
    STATE_FAULT = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_LW   = 3'd1,
    CLS_SW   = 3'd2,
    CLS_BEQ  = 3'd3,
    CLS_J    = 3'd4,
    CLS_ADDI = 3'd5,
    CLS_ILL  = 3'd6
  } instr_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_IMEM    = 2'd1;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd2;
  localparam logic [1:0] FAULT_DMEM    = 2'd3;

  // Every datapath strobe/select in one bundle so reset can blank them together.
  typedef struct packed {
    logic imem_req;
    logic ir_we;
    logic pc_we;
    logic rf_rd;
    logic rf_wr;
    logic dmem_req;
    logic dmem_we;
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic branch_sel;
    logic jump;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = 12'h000;

  // halt_req is only looked at when an instruction has finished.
  function automatic state_e boundary_state(input logic halt_req);
    return halt_req ? STATE_HALT : STATE_IF;
  endfunction

endpackage

// File: rtl/multi_period_decoder.sv
// Combinational instruction decoder.
// Maps opcode/funct to an instruction class, the ALU operation used in EX,
// and an illegal flag (unknown opcode, or R-type with unknown funct).
// Ports:
//   opcode  : opcode field
//   funct   : funct field (only meaningful for R-type)
//   cls     : instruction class
//   alu_op  : ALU operation for EX
//   illegal : instruction not supported
module multi_period_decoder
  import multi_period_sequencer_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALU_OP_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  output instr_class_e        cls,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal
);

  // Opcode/funct decode; illegal is the fall-through for anything unknown.
  always_comb begin
    cls     = CLS_ILL;
    alu_op  = ALU_OP_W'(ALU_ADD);
    illegal = 1'b1;
    case (opcode)
      OPCODE_W'(OP_RTYPE): begin
        cls     = CLS_R;
        illegal = 1'b0;
        case (funct)
          FUNCT_W'(FN_ADD): alu_op = ALU_OP_W'(ALU_ADD);
          FUNCT_W'(FN_SUB): alu_op = ALU_OP_W'(ALU_SUB);
          FUNCT_W'(FN_AND): alu_op = ALU_OP_W'(ALU_AND);
          FUNCT_W'(FN_OR):  alu_op = ALU_OP_W'(ALU_OR);
          FUNCT_W'(FN_SLT): alu_op = ALU_OP_W'(ALU_SLT);
          default: begin
            cls     = CLS_ILL;
            illegal = 1'b1;
          end
        endcase
      end
      OPCODE_W'(OP_LW):   begin cls = CLS_LW;   illegal = 1'b0; end
      OPCODE_W'(OP_SW):   begin cls = CLS_SW;   illegal = 1'b0; end
      OPCODE_W'(OP_BEQ):  begin cls = CLS_BEQ;  illegal = 1'b0; alu_op = ALU_OP_W'(ALU_SUB); end
      OPCODE_W'(OP_J):    begin cls = CLS_J;    illegal = 1'b0; end
      OPCODE_W'(OP_ADDI): begin cls = CLS_ADDI; illegal = 1'b0; end
      default: begin
        cls     = CLS_ILL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multi_period_sequencer.sv
// Multi-cycle control sequencer for the multi-period CPU datapath.
// Walks IF/ID/EX/MEM/WB with variable-latency memory handshakes and a
// wait-cycle timeout, parks in HALT at instruction boundaries on request,
// and locks into FAULT on illegal instructions or memory timeouts.
// Optional macro MULTI_PERIOD_PERF_CNT_EN adds retired-instruction and
// stall-cycle counters; without it those ports are constant 0.
// Ports:
//   clk, rst (async, active-low)
//   opcode, funct, zero, imem_ack, dmem_ack, halt_req : inputs
//   state                                            : current state code
//   imem_req..jump                                   : datapath strobes/selects
//   alu_op                                           : ALU operation
//   busy, fault, fault_code                          : status
//   instr_retired, stall_cycles                      : performance counters
module multi_period_sequencer
  import multi_period_sequencer_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int FUNCT_W     = 6,
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  input  logic                 halt_req,
  output logic [STATE_LEN-1:0] state,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 regfile_read_en,
  output logic                 regfile_write_en,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 reg_dst,
  output logic                 alu_src,
  output logic                 mem_to_reg,
  output logic                 branch_sel,
  output logic                 jump,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 busy,
  output logic                 fault,
  output logic [1:0]           fault_code,
  output logic [31:0]          instr_retired,
  output logic [31:0]          stall_cycles
);

  // Last wait count that may still be followed by another wait cycle.
  localparam logic [7:0]          TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = ALU_OP_W'(ALU_ADD);

  state_e              state_q, state_d;
  instr_class_e        cls_q, cls_d, dec_cls_s;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d, dec_alu_op_s, alu_op_s;
  logic                dec_illegal_s;
  logic [7:0]          wait_q, wait_d;
  logic [1:0]          fault_code_q, fault_code_d;
  ctrl_t               ctrl_s, ctrl_gated_s;

  multi_period_decoder #(
    .OPCODE_W (OPCODE_W),
    .FUNCT_W  (FUNCT_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_decoder (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (dec_cls_s),
    .alu_op  (dec_alu_op_s),
    .illegal (dec_illegal_s)
  );

  // State, latched instruction class/ALU op, ack wait counter and fault cause.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= STATE_IF;
      cls_q        <= CLS_R;
      alu_op_q     <= ALU_OP_ADD;
      wait_q       <= 8'd0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      alu_op_q     <= alu_op_d;
      wait_q       <= wait_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Next-state and control-strobe decode.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    alu_op_d     = alu_op_q;
    wait_d       = wait_q;
    fault_code_d = fault_code_q;
    ctrl_s       = CTRL_IDLE;
    alu_op_s     = ALU_OP_ADD;
    case (state_q)
      STATE_IF: begin
        ctrl_s.imem_req = 1'b1;
        // An ack on the timeout cycle is checked first, so it wins.
        if (imem_ack) begin
          ctrl_s.ir_we = 1'b1;
          state_d      = STATE_ID;
        end else if (wait_q == TIMEOUT_LAST) begin
          state_d      = STATE_FAULT;
          fault_code_d = FAULT_IMEM;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      STATE_ID: begin
        ctrl_s.rf_rd = 1'b1;
        cls_d        = dec_cls_s;
        alu_op_d     = dec_alu_op_s;
        if (dec_illegal_s) begin
          state_d      = STATE_FAULT;
          fault_code_d = FAULT_ILLEGAL;
        end else if (dec_cls_s == CLS_J) begin
          ctrl_s.jump  = 1'b1;
          ctrl_s.pc_we = 1'b1;
          state_d      = boundary_state(halt_req);
        end else begin
          state_d = STATE_EX;
        end
      end
      STATE_EX: begin
        alu_op_s       = alu_op_q;
        ctrl_s.alu_src = (cls_q == CLS_LW) || (cls_q == CLS_SW) || (cls_q == CLS_ADDI);
        case (cls_q)
          CLS_BEQ: begin
            ctrl_s.pc_we      = 1'b1;
            ctrl_s.branch_sel = zero;
            state_d           = boundary_state(halt_req);
          end
          CLS_LW, CLS_SW: state_d = STATE_MEM;
          default:        state_d = STATE_WB;
        endcase
      end
      STATE_MEM: begin
        ctrl_s.dmem_req = 1'b1;
        ctrl_s.dmem_we  = (cls_q == CLS_SW);
        if (dmem_ack) begin
          if (cls_q == CLS_SW) begin
            ctrl_s.pc_we = 1'b1;
            state_d      = boundary_state(halt_req);
          end else begin
            state_d = STATE_WB;
          end
        end else if (wait_q == TIMEOUT_LAST) begin
          state_d      = STATE_FAULT;
          fault_code_d = FAULT_DMEM;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      STATE_WB: begin
        ctrl_s.rf_wr      = 1'b1;
        ctrl_s.pc_we      = 1'b1;
        ctrl_s.reg_dst    = (cls_q == CLS_R);
        ctrl_s.mem_to_reg = (cls_q == CLS_LW);
        state_d           = boundary_state(halt_req);
      end
      STATE_HALT: begin
        if (halt_req) begin
          state_d = STATE_HALT;
        end else begin
          state_d = STATE_IF;
        end
      end
      STATE_FAULT: state_d = STATE_FAULT;
      default: begin
        // Unused encoding: treat as corruption and lock up.
        state_d      = STATE_FAULT;
        fault_code_d = FAULT_ILLEGAL;
      end
    endcase
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else begin
      wait_d = wait_d;
    end
  end

  // Reset blanks every strobe immediately, even though IF would request a fetch.
  assign ctrl_gated_s = rst ? ctrl_s : CTRL_IDLE;

  assign state            = state_q;
  assign imem_req         = ctrl_gated_s.imem_req;
  assign ir_we            = ctrl_gated_s.ir_we;
  assign pc_we            = ctrl_gated_s.pc_we;
  assign regfile_read_en  = ctrl_gated_s.rf_rd;
  assign regfile_write_en = ctrl_gated_s.rf_wr;
  assign dmem_req         = ctrl_gated_s.dmem_req;
  assign dmem_we          = ctrl_gated_s.dmem_we;
  assign reg_dst          = ctrl_gated_s.reg_dst;
  assign alu_src          = ctrl_gated_s.alu_src;
  assign mem_to_reg       = ctrl_gated_s.mem_to_reg;
  assign branch_sel       = ctrl_gated_s.branch_sel;
  assign jump             = ctrl_gated_s.jump;
  assign alu_op           = rst ? alu_op_s : ALU_OP_ADD;
  assign busy             = (state_q != STATE_HALT) && (state_q != STATE_FAULT);
  assign fault            = (state_q == STATE_FAULT);
  assign fault_code       = fault_code_q;

`ifdef MULTI_PERIOD_PERF_CNT_EN
  logic [31:0] instr_retired_q, stall_cycles_q;
  logic        stall_s;

  assign stall_s = ((state_q == STATE_IF)  && !imem_ack) ||
                   ((state_q == STATE_MEM) && !dmem_ack);

  // Retired-instruction and ack-stall counters, free-running with wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_retired_q <= 32'd0;
      stall_cycles_q  <= 32'd0;
    end else begin
      if (ctrl_gated_s.pc_we) begin
        instr_retired_q <= instr_retired_q + 32'd1;
      end
      if (stall_s) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  assign instr_retired = instr_retired_q;
  assign stall_cycles  = stall_cycles_q;
`else
  assign instr_retired = 32'd0;
  assign stall_cycles  = 32'd0;
`endif

endmodule

// File: tb/tb_multi_period_sequencer.sv
// Directed self-checking bench for multi_period_sequencer.
module tb_multi_period_sequencer;

`ifdef MULTI_PERIOD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_BAD   = 6'b111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        zero, imem_ack, dmem_ack, halt_req;
  logic [2:0]  state;
  logic        imem_req, ir_we, pc_we, regfile_read_en, regfile_write_en;
  logic        dmem_req, dmem_we, reg_dst, alu_src, mem_to_reg, branch_sel, jump;
  logic [3:0]  alu_op;
  logic        busy, fault;
  logic [1:0]  fault_code;
  logic [31:0] instr_retired, stall_cycles;

  int total = 0;
  int bad   = 0;

  logic [5:0] fn_tab [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [3:0] op_tab [4] = '{4'd1, 4'd2, 4'd3, 4'd4};

  multi_period_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .halt_req(halt_req),
    .state(state), .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we),
    .regfile_read_en(regfile_read_en), .regfile_write_en(regfile_write_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_dst(reg_dst),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .branch_sel(branch_sel),
    .jump(jump), .alu_op(alu_op), .busy(busy), .fault(fault),
    .fault_code(fault_code), .instr_retired(instr_retired),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leaves time 2 units past the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_code", fault_code, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_retired", instr_retired, 0);
    chk("rst_stall", stall_cycles, 0);
    step(); step();
    rst = 1'b1; #1;
    chk("if_imem_req", imem_req, 1);
    chk("if_busy", busy, 1);

    // add $3,$1,$2 : IF, ID, EX, WB, IF
    opcode = T_RTYPE; funct = 6'b100000; imem_ack = 1'b1; #1;
    chk("add_if_state", state, 0);
    chk("add_ir_we", ir_we, 1);
    step(); imem_ack = 1'b0; #1;
    chk("add_id_state", state, 1);
    chk("add_id_rd", regfile_read_en, 1);
    chk("add_id_pc_we", pc_we, 0);
    step();
    chk("add_ex_state", state, 2);
    chk("add_ex_alu_op", alu_op, 0);
    chk("add_ex_alu_src", alu_src, 0);
    step();
    chk("add_wb_state", state, 4);
    chk("add_wb_wr", regfile_write_en, 1);
    chk("add_wb_reg_dst", reg_dst, 1);
    chk("add_wb_pc_we", pc_we, 1);
    chk("add_wb_mem_to_reg", mem_to_reg, 0);
    step();
    chk("add_next_if", state, 0);

    // sub/and/or/slt ALU op in EX
    for (int i = 0; i < 4; i++) begin
      funct = fn_tab[i]; imem_ack = 1'b1; #1;
      step(); imem_ack = 1'b0; #1;
      step();
      chk("rtype_ex_alu_op", alu_op, op_tab[i]);
      step(); step();
      chk("rtype_back_if", state, 0);
    end

    // lw with dmem_ack delayed 3 cycles
    opcode = T_LW; imem_ack = 1'b1; #1;
    step(); imem_ack = 1'b0; #1;
    step();
    chk("lw_ex_alu_src", alu_src, 1);
    step();
    chk("lw_mem1_state", state, 3);
    chk("lw_mem1_req", dmem_req, 1);
    chk("lw_mem1_we", dmem_we, 0);
    step(); step(); step();
    dmem_ack = 1'b1; #1;
    chk("lw_mem4_state", state, 3);
    chk("lw_mem4_pc_we", pc_we, 0);
    step(); dmem_ack = 1'b0; #1;
    chk("lw_wb_state", state, 4);
    chk("lw_wb_mem_to_reg", mem_to_reg, 1);
    chk("lw_wb_reg_dst", reg_dst, 0);
    chk("lw_stall", stall_cycles, PERF ? 3 : 0);
    step();
    chk("lw_retired", instr_retired, PERF ? 6 : 0);

    // sw with immediate ack: 4 cycles
    opcode = T_SW; imem_ack = 1'b1; #1;
    step(); imem_ack = 1'b0; #1;
    step(); step();
    dmem_ack = 1'b1; #1;
    chk("sw_mem_state", state, 3);
    chk("sw_mem_we", dmem_we, 1);
    chk("sw_mem_pc_we", pc_we, 1);
    step(); dmem_ack = 1'b0; #1;
    chk("sw_back_if", state, 0);

    // beq taken then not taken
    opcode = T_BEQ; imem_ack = 1'b1; #1;
    step(); imem_ack = 1'b0; #1;
    step(); zero = 1'b1; #1;
    chk("beq1_ex_state", state, 2);
    chk("beq1_pc_we", pc_we, 1);
    chk("beq1_branch_sel", branch_sel, 1);
    chk("beq1_alu_op", alu_op, 1);
    step();
    chk("beq1_back_if", state, 0);
    imem_ack = 1'b1; #1;
    step(); imem_ack = 1'b0; #1;
    step(); zero = 1'b0; #1;
    chk("beq0_pc_we", pc_we, 1);
    chk("beq0_branch_sel", branch_sel, 0);
    step();
    chk("beq0_back_if", state, 0);

    // j: 2 cycles
    opcode = T_J; imem_ack = 1'b1; #1;
    step(); imem_ack = 1'b0; #1;
    chk("j_id_jump", jump, 1);
    chk("j_id_pc_we", pc_we, 1);
    step();
    chk("j_back_if", state, 0);

    // addi with halt_req raised in EX
    opcode = T_ADDI; imem_ack = 1'b1; #1;
    step(); imem_ack = 1'b0; #1;
    step(); halt_req = 1'b1; #1;
    chk("addi_ex_state", state, 2);
    chk("addi_ex_alu_src", alu_src, 1);
    step();
    chk("addi_wb_state", state, 4);
    chk("addi_wb_pc_we", pc_we, 1);
    step();
    chk("halt_state", state, 5);
    chk("halt_busy", busy, 0);
    chk("halt_imem_req", imem_req, 0);
    step();
    chk("halt_hold", state, 5);
    halt_req = 1'b0; #1;
    chk("halt_release_same_cycle", state, 5);
    step();
    chk("halt_exit_if", state, 0);
    chk("halt_exit_busy", busy, 1);
    chk("total_retired", instr_retired, PERF ? 11 : 0);

    // reset in the middle of MEM
    opcode = T_LW; imem_ack = 1'b1; #1;
    step(); imem_ack = 1'b0; #1;
    step(); step();
    chk("rmem_state", state, 3);
    rst = 1'b0; #1;
    chk("rmem_state_if", state, 0);
    chk("rmem_dmem_req", dmem_req, 0);
    chk("rmem_imem_req", imem_req, 0);
    chk("rmem_wr", regfile_write_en, 0);
    chk("rmem_retired", instr_retired, 0);
    step();
    chk("rmem_pc_we", pc_we, 0);
    rst = 1'b1; #1;
    chk("rmem_release_req", imem_req, 1);

    // illegal opcode
    opcode = T_BAD; imem_ack = 1'b1; #1;
    step(); imem_ack = 1'b0; #1;
    chk("ill_id_state", state, 1);
    chk("ill_id_pc_we", pc_we, 0);
    step();
    chk("ill_state", state, 6);
    chk("ill_fault", fault, 1);
    chk("ill_fault_code", fault_code, 2);
    chk("ill_busy", busy, 0);
    step(); step();
    chk("ill_sticky", state, 6);
    chk("ill_pc_we", pc_we, 0);
    rst = 1'b0; #1;
    chk("ill_rst_fault", fault, 0);
    chk("ill_rst_code", fault_code, 0);
    step(); rst = 1'b1; #1;

    // imem_ack never arrives
    for (int i = 0; i < 15; i++) begin
      chk("to_if_state", state, 0);
      step();
    end
    chk("to_fault_state", state, 6);
    chk("to_fault_code", fault_code, 1);
    chk("to_busy", busy, 0);
    chk("to_stall", stall_cycles, PERF ? 15 : 0);
    step(); step(); step();
    chk("to_sticky", state, 6);
    rst = 1'b0; #1;
    chk("to_rst_state", state, 0);
    step(); rst = 1'b1; #1;

    // ack on the timeout cycle wins
    for (int i = 0; i < 14; i++) step();
    opcode = T_J; imem_ack = 1'b1; #1;
    chk("ackwin_ir_we", ir_we, 1);
    step(); imem_ack = 1'b0; #1;
    chk("ackwin_id", state, 1);
    chk("ackwin_no_fault", fault, 0);
    step();

    // dmem timeout
    opcode = T_LW; imem_ack = 1'b1; #1;
    step(); imem_ack = 1'b0; #1;
    step(); step();
    for (int i = 0; i < 14; i++) step();
    chk("dto_last_mem", state, 3);
    step();
    chk("dto_state", state, 6);
    chk("dto_code", fault_code, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
